// File: rtl/logic_level_rx.sv
// Hysteresis slicer with consecutive-sample deglitch: turns an ADC code stream into a clean logic level plus edge events.
// Optional stuck-between-thresholds detector is enabled by defining LOGIC_LEVEL_RX_XDET_EN.
module logic_level_rx #(
   parameter int W         = 12,
   parameter int DELAY     = 4,
   parameter int MID_LIMIT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sample_valid,
   input  logic [W-1:0] sample,
   input  logic [W-1:0] thr_hi,
   input  logic [W-1:0] thr_lo,
   output logic         y,
   output logic         known,
   output logic         rise_evt,
   output logic         fall_evt,
   output logic         cfg_err,
   output logic         x_flag
);

   localparam int CW = $clog2(DELAY + 1);
   localparam logic [CW-1:0] DLY = CW'(DELAY);

   if (DELAY < 1 || MID_LIMIT < 1) begin : g_bad_param
      $error("logic_level_rx: DELAY and MID_LIMIT must be >= 1");
   end

   typedef enum logic [1:0] {S_UNK, S_LOW, S_HIGH} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          cand, cand_n;
   logic          y_n, rise_n, fall_n;
   logic          cls_hi, cls_lo;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= DLY) ? DLY : v + CW'(1);
   endfunction

   assign cls_hi = (sample >= thr_hi);
   assign cls_lo = (sample <= thr_lo) && !cls_hi;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cand_n  = cand;
      y_n     = y;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      if (cfg_err) begin
         cnt_n = '0;
      end else if (sample_valid) begin
         case (state)
            S_UNK: begin
               if (cls_hi || cls_lo) begin
                  if (cls_hi == cand) begin
                     cnt_n = sat_inc(cnt);
                  end else begin
                     cand_n = cls_hi;
                     cnt_n  = CW'(1);
                  end
                  // first level is adopted silently: there was no prior level to leave
                  if (cnt_n == DLY) begin
                     state_n = cand_n ? S_HIGH : S_LOW;
                     y_n     = cand_n;
                     cnt_n   = '0;
                  end
               end else begin
                  cnt_n = '0;
               end
            end
            S_LOW: begin
               if (cls_hi) begin
                  cnt_n = sat_inc(cnt);
                  if (cnt_n == DLY) begin
                     state_n = S_HIGH;
                     y_n     = 1'b1;
                     rise_n  = 1'b1;
                     cnt_n   = '0;
                  end
               end else if (cls_lo) begin
                  cnt_n = '0;
               end
            end
            S_HIGH: begin
               if (cls_lo) begin
                  cnt_n = sat_inc(cnt);
                  if (cnt_n == DLY) begin
                     state_n = S_LOW;
                     y_n     = 1'b0;
                     fall_n  = 1'b1;
                     cnt_n   = '0;
                  end
               end else if (cls_hi) begin
                  cnt_n = '0;
               end
            end
            default: begin
               state_n = S_UNK;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_UNK;
         cnt      <= '0;
         cand     <= 1'b0;
         y        <= 1'b0;
         rise_evt <= 1'b0;
         fall_evt <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         cand     <= cand_n;
         y        <= y_n;
         rise_evt <= rise_n;
         fall_evt <= fall_n;
         cfg_err  <= (thr_lo >= thr_hi);
      end
   end

`ifdef LOGIC_LEVEL_RX_XDET_EN
   localparam int MW = $clog2(MID_LIMIT + 1);
   localparam logic [MW-1:0] MLIM = MW'(MID_LIMIT);

   logic [MW-1:0] midcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         midcnt <= '0;
      end else if (sample_valid && !cfg_err) begin
         if (cls_hi || cls_lo)
            midcnt <= '0;
         else if (midcnt != MLIM)
            midcnt <= midcnt + MW'(1);
      end
   end

   assign x_flag = (midcnt == MLIM);
`else
   assign x_flag = 1'b0;
`endif

   assign known = (state != S_UNK) && !x_flag;

endmodule
